// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: fetch FSM encoding,
// pipeline constants and opcode values used by decode and the stall unit.
package mips_pkg;

    // All-zero word; decode treats it as a NOP (sll $0,$0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Fetch FSM encoding (2 bits, kept as plain constants for legacy tools).
    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_REQ  = 2'd1;
    localparam logic [1:0] FETCH_FULL = 2'd2;
    localparam logic [1:0] FETCH_DROP = 2'd3;

    // Primary opcodes shared with decode and the stall unit.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Word-align a PC; the two low bits of any target are forced to zero.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word (instruction + its PC) that
// arrived while decode was held. Clear wins over load; unload empties it.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc_i,
    output logic [31:0] data_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    logic [31:0] data_q;
    logic [31:0] pc_q;
    logic        valid_q;

    // Valid flag: clear and unload empty the entry, load fills it.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (clear_i || unload_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end
    end

    // Payload capture; only meaningful while valid_q is set.
    // NOTE: the payload is reset too, so a stale word can never leak out as X in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= NOP_INSTR;
            pc_q   <= '0;
        end else if (load_i && !clear_i) begin
            data_q <= data_i;
            pc_q   <= pc_i;
        end
    end

    assign data_o  = data_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register. Owns the PC, fetches over a level req/ack
// handshake, parks one word in a skid buffer while decode is held, inserts
// zero bubbles and flushes on a taken branch/jump redirect.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IRD,
    output logic [31:0] pcD,
    output logic        ex_bubble
);

    logic [1:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] ird_q,      ird_d;
    logic [31:0] pcd_q,      pcd_d;

    logic        fb_load;
    logic        fb_unload;
    logic        fb_clear;
    logic [31:0] fb_data;
    logic [31:0] fb_pc;
    logic        fb_valid;

    // A request is in flight in REQ and DROP; DROP keeps presenting the
    // abandoned address until memory answers, while pc already holds the target.
    assign imem_req  = (state_q == FETCH_REQ) || (state_q == FETCH_DROP);
    assign imem_addr = (state_q == FETCH_DROP) ? req_addr_q : pc_q;
    assign IRD       = ird_q;
    assign pcD       = pcd_q;
    assign ex_bubble = ~stall;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (fb_load),
        .unload_i (fb_unload),
        .clear_i  (fb_clear),
        .data_i   (imem_rdata),
        .pc_i     (pc_q),
        .data_o   (fb_data),
        .pc_o     (fb_pc),
        .valid_o  (fb_valid)
    );

    // Next-state logic for FSM, PC, retained request address and IF/ID register.
    // NOTE: every output of this block gets a default first, otherwise latches are inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        ird_d      = ird_q;
        pcd_d      = pcd_q;
        fb_load    = 1'b0;
        fb_unload  = 1'b0;
        fb_clear   = 1'b0;

        if (stall && redirect) begin
            // Taken redirect: flush the delay-slot word and any buffered word,
            // and discard a word acked this very cycle.
            pc_d     = pc_align(redirect_pc);
            ird_d    = NOP_INSTR;
            pcd_d    = '0;
            fb_clear = 1'b1;
            if (imem_req && !imem_ack) begin
                state_d = FETCH_DROP;
                // Entering DROP from REQ: remember the address memory is still serving.
                if (state_q == FETCH_REQ) begin
                    req_addr_d = pc_q;
                end
            end else begin
                state_d = FETCH_REQ;
            end
        end else begin
            // Decode advances: oldest word first (buffer), then a fresh ack, else a bubble.
            if (stall) begin
                if (fb_valid) begin
                    ird_d     = fb_data;
                    pcd_d     = fb_pc;
                    fb_unload = 1'b1;
                end else if ((state_q == FETCH_REQ) && imem_ack) begin
                    ird_d = imem_rdata;
                    pcd_d = pc_q;
                end else begin
                    ird_d = NOP_INSTR;
                    pcd_d = '0;
                end
            end

            case (state_q)
                FETCH_IDLE: state_d = FETCH_REQ;
                FETCH_REQ: begin
                    if (imem_ack) begin
                        pc_d = pc_q + PC_STEP;
                        // Decode is held: park the word and stop fetching.
                        if (!stall) begin
                            fb_load = 1'b1;
                            state_d = FETCH_FULL;
                        end
                    end
                end
                FETCH_FULL: if (stall) state_d = FETCH_REQ;
                FETCH_DROP: if (imem_ack) state_d = FETCH_REQ;
                default:    state_d = FETCH_IDLE;
            endcase
        end
    end

    // Fetch-side state: FSM, PC and the retained request address.
    // NOTE: asynchronous active-low reset, so the reset branch sits in the sensitivity list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // IF/ID pipeline register presented to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ird_q <= NOP_INSTR;
            pcd_q <= '0;
        end else begin
            ird_q <= ird_d;
            pcd_q <= pcd_d;
        end
    end

endmodule
